test_nios2_0_cpu_mult_seq: RTL



---
 rtl/test_nios2_0_cpu_mult_pkg.sv | 24 ++
 rtl/test_nios2_0_cpu_mult_combine.sv | 38 +++
 rtl/test_nios2_0_cpu_mult_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/test_nios2_0_cpu_mult_pkg.sv
// rtl/test_nios2_0_cpu_mult_pkg.sv - shared op codes, state enum and widths for the multiply sequencer
package test_nios2_0_cpu_mult_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int MID_W  = 33;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSS = 2'b10;
    localparam logic [1:0] OP_MULXSU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_LO,
        ST_WAIT_LO,
        ST_CAPT_LO,
        ST_ISSUE_HI,
        ST_WAIT_HI,
        ST_CAPT_HI,
        ST_RESP
    } state_t;

endpackage

// File: rtl/test_nios2_0_cpu_mult_combine.sv
// rtl/test_nios2_0_cpu_mult_combine.sv - combines LL/MID/HH into low and high result words
// MUL_SIGNED_HI_EN adds the signed high-word correction for MULXSS/MULXSU.
module test_nios2_0_cpu_mult_combine
    import test_nios2_0_cpu_mult_pkg::*;
(
    input  logic [WORD_W-1:0] ll,
    input  logic [MID_W-1:0]  mid,
    input  logic [WORD_W-1:0] hh,
    output logic [WORD_W-1:0] lo,
    output logic [WORD_W-1:0] hi_u
`ifdef MUL_SIGNED_HI_EN
    ,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [1:0]        op,
    output logic [WORD_W-1:0] hi_s
`endif
);

    logic [WORD_W:0] lo_sum;

    // The carry out of the low word feeds the high word.
    assign lo_sum = {1'b0, ll} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
    assign lo     = lo_sum[WORD_W-1:0];
    assign hi_u   = hh + {15'h0, mid[MID_W-1:HALF_W]} + {31'h0, lo_sum[WORD_W]};

`ifdef MUL_SIGNED_HI_EN
    always_comb begin
        hi_s = hi_u;
        case (op)
            OP_MULXSS: hi_s = hi_u - (a[WORD_W-1] ? b : '0) - (b[WORD_W-1] ? a : '0);
            OP_MULXSU: hi_s = hi_u - (a[WORD_W-1] ? b : '0);
            default:   hi_s = hi_u;
        endcase
    end
`endif

endmodule

// File: rtl/test_nios2_0_cpu_mult_seq.sv
// rtl/test_nios2_0_cpu_mult_seq.sv - request/response sequencer for the three-partial-product multiplier cell
// MUL_SIGNED_HI_EN selects signed high-word results for ops 10/11.
module test_nios2_0_cpu_mult_seq
    import test_nios2_0_cpu_mult_pkg::*;
#(
    parameter int CELL_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [WORD_W-1:0] req_src1,
    input  logic [WORD_W-1:0] req_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic [WORD_W-1:0] E_src1,
    output logic [WORD_W-1:0] E_src2,
    output logic              M_en,
    input  logic [WORD_W-1:0] M_mul_cell_p1,
    input  logic [WORD_W-1:0] M_mul_cell_p2,
    input  logic [WORD_W-1:0] M_mul_cell_p3
);

    localparam logic [1:0] WAIT_LAST = 2'((CELL_LATENCY > 1) ? CELL_LATENCY - 2 : 0);

    state_t            state_q, state_d;
    logic [1:0]        wait_cnt;
    logic [1:0]        op_q;
    logic [WORD_W-1:0] a_q, b_q;
    logic              hi_phase;
    logic [WORD_W-1:0] ll_q, hh_q, rsp_data_q;
    logic [MID_W-1:0]  mid_q;

    logic [WORD_W-1:0] ll_in, hh_in, lo_word, hi_u_word, hi_word;
    logic [MID_W-1:0]  mid_in;

    // Products go straight into the combiner during the capture cycle so the result register loads on time.
    assign ll_in  = (state_q == ST_CAPT_LO) ? M_mul_cell_p1 : ll_q;
    assign mid_in = (state_q == ST_CAPT_LO) ? ({1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3}) : mid_q;
    assign hh_in  = (state_q == ST_CAPT_HI) ? M_mul_cell_p1 : hh_q;

    test_nios2_0_cpu_mult_combine u_combine (
        .ll   (ll_in),
        .mid  (mid_in),
        .hh   (hh_in),
        .lo   (lo_word),
        .hi_u (hi_u_word)
`ifdef MUL_SIGNED_HI_EN
        ,
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .hi_s (hi_word)
`endif
    );

`ifndef MUL_SIGNED_HI_EN
    assign hi_word = hi_u_word;
`endif

    // The second pass moves the high halves into the low operand slots so the cell's LL yields HH.
    assign E_src1   = hi_phase ? {{HALF_W{1'b0}}, a_q[WORD_W-1:HALF_W]} : a_q;
    assign E_src2   = hi_phase ? {{HALF_W{1'b0}}, b_q[WORD_W-1:HALF_W]} : b_q;
    assign rsp_data = rsp_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt   <= '0;
            op_q       <= OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            hi_phase   <= 1'b0;
            ll_q       <= '0;
            mid_q      <= '0;
            hh_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        a_q      <= req_src1;
                        b_q      <= req_src2;
                        hi_phase <= 1'b0;
                    end
                end
                ST_ISSUE_LO, ST_ISSUE_HI: wait_cnt <= '0;
                ST_WAIT_LO, ST_WAIT_HI:   wait_cnt <= wait_cnt + 2'd1;
                ST_CAPT_LO: begin
                    ll_q  <= ll_in;
                    mid_q <= mid_in;
                    if (op_q == OP_MUL) begin
                        rsp_data_q <= lo_word;
                    end else begin
                        hi_phase <= 1'b1;
                    end
                end
                ST_CAPT_HI: begin
                    hh_q       <= hh_in;
                    rsp_data_q <= hi_word;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        M_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_ISSUE_LO;
            end
            ST_ISSUE_LO: begin
                M_en    = 1'b1;
                state_d = (CELL_LATENCY > 1) ? ST_WAIT_LO : ST_CAPT_LO;
            end
            ST_WAIT_LO: if (wait_cnt == WAIT_LAST) state_d = ST_CAPT_LO;
            ST_CAPT_LO: state_d = (op_q == OP_MUL) ? ST_RESP : ST_ISSUE_HI;
            ST_ISSUE_HI: begin
                M_en    = 1'b1;
                state_d = (CELL_LATENCY > 1) ? ST_WAIT_HI : ST_CAPT_HI;
            end
            ST_WAIT_HI: if (wait_cnt == WAIT_LAST) state_d = ST_CAPT_HI;
            ST_CAPT_HI: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
